// File: rtl/fetch_unit_if.sv
// Decoder-side instruction handshake of fetch_unit. An instruction transfers on any
// posedge with out_valid && out_ready; all fields hold while out_valid && !out_ready.
interface fetch_unit_if;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_opcode;
  logic [7:0] out_imm;
  logic       out_long;
  logic [7:0] out_pc;

  modport master (
    output out_valid, out_opcode, out_imm, out_long, out_pc,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_opcode, out_imm, out_long, out_pc,
    output out_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// nRisc instruction fetch: owns the PC, assembles 1/2-byte instructions from byte memory.
// Optional halt-on-opcode support is enabled by defining FETCH_HALT_EN.
module fetch_unit #(
  parameter logic [7:0] RESET_PC    = 8'h00,
  parameter logic [7:0] HALT_OPCODE = 8'h9C
) (
  input  logic         clock,
  input  logic         reset_n,
  output logic [7:0]   pc,
  input  logic [7:0]   mem_data,
  input  logic         branch_valid,
  input  logic [7:0]   branch_target,
  fetch_unit_if.master dec,
  output logic         halted,
  output logic [2:0]   dbg_state
);

  typedef enum logic [2:0] {
    S_OP_A  = 3'd0,
    S_OP_B  = 3'd1,
    S_IM_A  = 3'd2,
    S_IM_B  = 3'd3,
    S_VALID = 3'd4
`ifdef FETCH_HALT_EN
    , S_HALT = 3'd5
`endif
  } state_t;

  state_t state;
  state_t state_next;
  logic   is_long;
  logic   take_branch;

  // Each byte is addressed for two cycles (x_A, x_B); mem_data is used at the end of x_B.
  assign is_long   = (mem_data[7:6] == 2'b01);
  assign dbg_state = state;

`ifdef FETCH_HALT_EN
  logic halt_xfer;
  assign halt_xfer   = dec.out_valid && dec.out_ready && (dec.out_opcode == HALT_OPCODE);
  // A halting transfer wins over a same-cycle redirect.
  assign take_branch = branch_valid && (state != S_HALT) && !halt_xfer;
`else
  logic unused_halt_opcode;
  assign unused_halt_opcode = ^HALT_OPCODE;
  assign take_branch        = branch_valid;
`endif

  always_comb begin
    state_next = state;
    case (state)
      S_OP_A:  state_next = S_OP_B;
      S_OP_B:  state_next = is_long ? S_IM_A : S_VALID;
      S_IM_A:  state_next = S_IM_B;
      S_IM_B:  state_next = S_VALID;
      S_VALID: if (dec.out_ready) state_next = S_OP_A;
`ifdef FETCH_HALT_EN
      S_HALT:  state_next = S_HALT;
`endif
      default: state_next = S_OP_A;
    endcase
`ifdef FETCH_HALT_EN
    if (halt_xfer) state_next = S_HALT;
`endif
    if (take_branch) state_next = S_OP_A;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= S_OP_A;
    else          state <= state_next;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pc             <= RESET_PC;
      dec.out_valid  <= 1'b0;
      dec.out_opcode <= 8'h00;
      dec.out_imm    <= 8'h00;
      dec.out_long   <= 1'b0;
      dec.out_pc     <= 8'h00;
    end else begin
      dec.out_valid <= (state_next == S_VALID);
      if (take_branch)
        pc <= branch_target;
      else if (state == S_OP_B || state == S_IM_B)
        pc <= pc + 8'd1;
      // A redirect discards whatever byte would have been latched this edge.
      if (!take_branch && state == S_OP_B) begin
        dec.out_opcode <= mem_data;
        dec.out_pc     <= pc;
        dec.out_long   <= is_long;
        if (!is_long) dec.out_imm <= 8'h00;
      end
      if (!take_branch && state == S_IM_B)
        dec.out_imm <= mem_data;
    end
  end

`ifdef FETCH_HALT_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) halted <= 1'b0;
    else          halted <= (state_next == S_HALT);
  end
`else
  assign halted = 1'b0;
`endif

endmodule
